video_write_queue: RTL and testbench

Buffers in-window video writes from the video cache stage and drains them into the framebuffer RAM write port. It sits directly downstream of the video cache and upstream of the framebuffer memory. The scanout reader owns the framebuffer port whenever it asserts `fb_busy`, so CPU-side video writes queue here and drain only in idle cycles. Addresses are translated from CPU space (0x8000–0xF530) to a 15-bit framebuffer offset.

---
 rtl/video_write_queue_if.sv | 26 ++
 rtl/video_write_queue.sv | 105 ++++++++++
 tb/tb_video_write_queue.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/video_write_queue_if.sv
// Bundles the video-cache write request, framebuffer write port and status signals of video_write_queue.
// master = upstream cache / scanout side, slave = the queue itself.
interface video_write_queue_if #(
    parameter int DEPTH_LOG2 = 3
);
    logic                  in_valid;
    logic [15:0]           in_addr;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  fb_busy;
    logic                  fb_we;
    logic [14:0]           fb_addr;
    logic [7:0]            fb_data;
    logic [DEPTH_LOG2:0]   level;
    logic                  bad_addr;

    modport master (
        output in_valid, in_addr, in_data, fb_busy,
        input  in_ready, fb_we, fb_addr, fb_data, level, bad_addr
    );

    modport slave (
        input  in_valid, in_addr, in_data, fb_busy,
        output in_ready, fb_we, fb_addr, fb_data, level, bad_addr
    );
endinterface

// File: rtl/video_write_queue.sv
// Queues in-window CPU video writes and drains them to the framebuffer port in idle (fb_busy low) cycles.
// Latency: accept at edge E, earliest pop at E+1 with fb_we high for the following cycle; one push + one pop per cycle.
// Backpressure: in_ready = !full from level only; VWQ_COALESCE_EN merges a write into the newest entry of the same offset.
module video_write_queue #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    video_write_queue_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = (DEPTH_LOG2)'(1);

    typedef struct packed {
        logic [14:0] off;
        logic [7:0]  dat;
    } entry_t;

    entry_t                mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  fb_we_q, fb_we_d;
    logic [14:0]           fb_addr_q, fb_addr_d;
    logic [7:0]            fb_data_q, fb_data_d;
    logic                  bad_addr_q, bad_addr_d;

    logic                  full, empty, accept, in_win, pop, push, coalesce;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_idx, newest_idx;
    entry_t                mem_wdat;

    always_comb begin
        full       = (level_q == FULL_LEVEL);
        empty      = (level_q == '0);
        accept     = bus.in_valid && !full;
        in_win     = (bus.in_addr >= 16'h8000) && (bus.in_addr <= 16'hF530);
        pop        = !empty && !bus.fb_busy;
        newest_idx = wr_ptr_q - PTR_ONE;
`ifdef VWQ_COALESCE_EN
        // A newest entry that is also the departing head cannot absorb the write.
        coalesce   = accept && in_win && !empty
                     && (mem_q[newest_idx].off == bus.in_addr[14:0])
                     && !((level_q == LEVEL_ONE) && pop);
`else
        coalesce   = 1'b0;
`endif
        push       = accept && in_win && !coalesce;

        mem_we       = push || coalesce;
        mem_idx      = coalesce ? newest_idx : wr_ptr_q;
        mem_wdat.off = bus.in_addr[14:0];
        mem_wdat.dat = bus.in_data;

        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d    = level_q;
        if (push && !pop) begin
            level_d = level_q + LEVEL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LEVEL_ONE;
        end

        fb_we_d    = pop;
        fb_addr_d  = pop ? mem_q[rd_ptr_q].off : fb_addr_q;
        fb_data_d  = pop ? mem_q[rd_ptr_q].dat : fb_data_q;
        bad_addr_d = bad_addr_q || (accept && !in_win);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            bad_addr_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= mem_wdat;
        end
    end

    assign bus.in_ready = !full;
    assign bus.fb_we    = fb_we_q;
    assign bus.fb_addr  = fb_addr_q;
    assign bus.fb_data  = fb_data_q;
    assign bus.level    = level_q;
    assign bus.bad_addr = bad_addr_q;
endmodule

// File: tb/tb_video_write_queue.sv
// Directed plus randomized bench for video_write_queue against a queue-based reference model.
module tb_video_write_queue;
    localparam int DL2   = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    video_write_queue_if #(.DEPTH_LOG2(DL2)) bus();
    video_write_queue #(.DEPTH_LOG2(DL2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    logic [14:0] m_off[$];
    logic [7:0]  m_dat[$];
    logic        exp_we;
    logic [14:0] exp_addr;
    logic [7:0]  exp_data;
    logic        exp_bad;
    logic        last_acc;
    int          obs_strobes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("fb_we",    32'(bus.fb_we),    32'(exp_we));
        chk("fb_addr",  32'(bus.fb_addr),  32'(exp_addr));
        chk("fb_data",  32'(bus.fb_data),  32'(exp_data));
        chk("level",    32'(bus.level),    32'(m_off.size()));
        chk("bad_addr", 32'(bus.bad_addr), 32'(exp_bad));
        chk("in_ready", 32'(bus.in_ready), 32'(m_off.size() < DEPTH));
    endtask

    task automatic model_reset();
        m_off.delete();
        m_dat.delete();
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_bad  = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [7:0] d, input logic busy);
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.fb_busy  = busy;
    endtask

    // Predict the effect of the next rising edge from the current inputs, then clock and compare.
    task automatic tick();
        int          sz;
        logic        acc, win, pop, coal;
        logic [15:0] offs;
        sz   = m_off.size();
        acc  = bus.in_valid && (sz < DEPTH);
        win  = (bus.in_addr >= 16'h8000) && (bus.in_addr <= 16'hF530);
        pop  = (sz > 0) && !bus.fb_busy;
        coal = 1'b0;
`ifdef VWQ_COALESCE_EN
        if (acc && win && sz > 0 && m_off[sz-1] == bus.in_addr[14:0] && !(sz == 1 && pop))
            coal = 1'b1;
`endif
        if (coal) m_dat[sz-1] = bus.in_data;
        exp_we = pop;
        if (pop) begin
            exp_addr = m_off.pop_front();
            exp_data = m_dat.pop_front();
        end
        if (acc && !win) exp_bad = 1'b1;
        if (acc && win && !coal) begin
            offs = bus.in_addr - 16'h8000;
            m_off.push_back(offs[14:0]);
            m_dat.push_back(bus.in_data);
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        if (bus.fb_we) obs_strobes++;
        check_outputs();
    endtask

    initial begin
        int          r;
        logic [15:0] a;
        obs_strobes = 0;
        last_acc    = 1'b0;
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 8'h0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // Single write, minimum latency
        drive(1'b1, 16'h8000, 8'hAA, 1'b0); tick();
        drive(1'b0, 16'h0, 8'h0, 1'b0);     tick();
        chk("t1_we",    32'(bus.fb_we),   32'h1);
        chk("t1_addr",  32'(bus.fb_addr), 32'h0);
        chk("t1_data",  32'(bus.fb_data), 32'hAA);
        chk("t1_level", 32'(bus.level),   32'h0);

        // Window boundaries
        drive(1'b1, 16'hF530, 8'h55, 1'b0); tick();
        drive(1'b1, 16'hF531, 8'h66, 1'b0); tick();
        chk("t2_addr", 32'(bus.fb_addr),  32'h7530);
        chk("t2_data", 32'(bus.fb_data),  32'h55);
        chk("t2_bad",  32'(bus.bad_addr), 32'h1);
        drive(1'b1, 16'h7FFF, 8'h77, 1'b0); tick();
        drive(1'b0, 16'h0, 8'h0, 1'b0);     tick();
        chk("t2_bad_hold", 32'(bus.bad_addr), 32'h1);
        chk("t2_no_strobe", 32'(bus.fb_we), 32'h0);

        // Fill under fb_busy, then drain
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'h9000 + 16'(i), 8'(i + 16), 1'b1);
            tick();
        end
        chk("t3_full_level", 32'(bus.level),    32'h8);
        chk("t3_full_ready", 32'(bus.in_ready), 32'h0);
        obs_strobes = 0;
        for (int i = 8; i < 10; i++) begin
            last_acc = 1'b0;
            for (int k = 0; k < 20 && !last_acc; k++) begin
                drive(1'b1, 16'h9000 + 16'(i), 8'(i + 16), 1'b0);
                tick();
            end
            chk("t3_late_accept", 32'(last_acc), 32'h1);
        end
        drive(1'b0, 16'h0, 8'h0, 1'b0);
        repeat (12) tick();
        chk("t3_strobes", 32'(obs_strobes), 32'd10);

        // Streaming: one push per cycle across several pointer laps
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, 16'hA000 + 16'(i * 3), 8'($urandom), 1'b0);
            tick();
            chk("t4_level", 32'(bus.level), 32'h1);
            if (i > 0) chk("t4_b2b", 32'(bus.fb_we), 32'h1);
        end
        drive(1'b0, 16'h0, 8'h0, 1'b0);
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       a = 16'h7FFF;
                1:       a = 16'h8000;
                2:       a = 16'hF530;
                3:       a = 16'hF531;
                4, 5:    a = 16'h8010;
                default: a = 16'($urandom_range(32'h8000, 32'hF530));
            endcase
            drive($urandom_range(0, 3) != 0, a, 8'($urandom), $urandom_range(0, 2) == 0);
            tick();
        end
        drive(1'b0, 16'h0, 8'h0, 1'b0);
        repeat (10) tick();

        // Reset mid-operation with a strobe in flight
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 16'hC000 + 16'(i), 8'(i), 1'b1);
            tick();
        end
        drive(1'b0, 16'h0, 8'h0, 1'b0);
        tick();
        chk("t5_pre_we",    32'(bus.fb_we), 32'h1);
        chk("t5_pre_level", 32'(bus.level), 32'h5);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_rst_we",    32'(bus.fb_we),    32'h0);
        chk("t5_rst_level", 32'(bus.level),    32'h0);
        chk("t5_rst_ready", 32'(bus.in_ready), 32'h1);
        chk("t5_rst_bad",   32'(bus.bad_addr), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs_strobes = 0;
        repeat (6) tick();
        chk("t5_no_strobes", 32'(obs_strobes), 32'h0);

        // Same-offset writes while stalled
        drive(1'b1, 16'h8010, 8'h01, 1'b1); tick();
        drive(1'b1, 16'h8010, 8'h02, 1'b1); tick();
`ifdef VWQ_COALESCE_EN
        chk("t6_level", 32'(bus.level), 32'h1);
`else
        chk("t6_level", 32'(bus.level), 32'h2);
`endif
        obs_strobes = 0;
        drive(1'b0, 16'h0, 8'h0, 1'b0);
        repeat (4) tick();
`ifdef VWQ_COALESCE_EN
        chk("t6_strobes", 32'(obs_strobes), 32'h1);
`else
        chk("t6_strobes", 32'(obs_strobes), 32'h2);
`endif
        chk("t6_last_data", 32'(bus.fb_data), 32'h02);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
